// File: rtl/matrix_res_streamer.sv
// ============================================================================
//  Module   : matrix_res_streamer
//  Purpose  : Reads a dim_m x dim_n result matrix stored row-major in a BRAM
//             starting at addr_base and streams it out one element at a time
//             on a valid/ready handshake, tagged with its row/col index.
//  Ports    : clk, rst_n            - clock, async active-low reset
//             start / done / busy   - level request, completion, activity
//             dim_m, dim_n          - result rows/cols (1..16 valid)
//             addr_base             - BRAM address of element (0,0)
//             mem_rd_en/addr/data   - BRAM read port (1-cycle read latency)
//             out_valid/out_ready   - element stream handshake
//             out_data/row/col      - element value and its zero-based index
//             out_last, out_eol     - final element / end-of-row markers
//  Options  : MATRIX_STREAM_EOL_EN  - when defined, out_eol flags every
//             element in the last column; otherwise out_eol is tied to 0.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef ELEMENT_WIDTH
`define ELEMENT_WIDTH 8
`endif
`ifndef BRAM_ADDR_WIDTH
`define BRAM_ADDR_WIDTH 10
`endif

module matrix_res_streamer #(
  parameter int ELEMENT_WIDTH = `ELEMENT_WIDTH,
  parameter int ADDR_WIDTH    = `BRAM_ADDR_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  output logic                     done,
  output logic                     busy,
  input  logic [4:0]               dim_m,
  input  logic [4:0]               dim_n,
  input  logic [ADDR_WIDTH-1:0]    addr_base,
  output logic                     mem_rd_en,
  output logic [ADDR_WIDTH-1:0]    mem_rd_addr,
  input  logic [ELEMENT_WIDTH-1:0] mem_rd_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [ELEMENT_WIDTH-1:0] out_data,
  output logic [4:0]               out_row,
  output logic [4:0]               out_col,
  output logic                     out_last,
  output logic                     out_eol
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_READ    = 3'd1,
    ST_WAIT    = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_PRESENT = 3'd4,
    ST_DONE    = 3'd5
  } state_t;

  state_t state, state_nxt;

  logic [4:0]            m_q;
  logic [4:0]            n_q;
  logic [ADDR_WIDTH-1:0] base_q;
  logic [ADDR_WIDTH-1:0] offset_q;   // row-major element index, wraps naturally
  logic [4:0]            row_q;
  logic [4:0]            col_q;

  logic dims_bad;
  logic col_at_end;
  logic row_at_end;
  logic xfer;
  logic eol_next;

  assign dims_bad   = (dim_m == 5'd0) || (dim_m > 5'd16) ||
                      (dim_n == 5'd0) || (dim_n > 5'd16);
  assign col_at_end = (col_q == n_q - 5'd1);
  assign row_at_end = (row_q == m_q - 5'd1);
  assign xfer       = (state == ST_PRESENT) && out_ready;

`ifdef MATRIX_STREAM_EOL_EN
  assign eol_next = col_at_end;
`else
  assign eol_next = 1'b0;
`endif

  // Status and handshake flags decode straight from the state so that an
  // asynchronous reset clears them in the same instant as the state.
  assign busy      = (state != ST_IDLE) && (state != ST_DONE);
  assign done      = (state == ST_DONE);
  assign out_valid = (state == ST_PRESENT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    mem_rd_en   = 1'b0;
    mem_rd_addr = '0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_nxt = dims_bad ? ST_DONE : ST_READ;
        end
      end
      ST_READ: begin
        mem_rd_en   = 1'b1;
        mem_rd_addr = base_q + offset_q;
        state_nxt   = ST_WAIT;
      end
      ST_WAIT: begin
        state_nxt = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        state_nxt = ST_PRESENT;
      end
      ST_PRESENT: begin
        if (out_ready) begin
          state_nxt = out_last ? ST_DONE : ST_READ;
        end
      end
      ST_DONE: begin
        if (!start) begin
          state_nxt = ST_IDLE;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_q      <= '0;
      n_q      <= '0;
      base_q   <= '0;
      offset_q <= '0;
      row_q    <= '0;
      col_q    <= '0;
      out_data <= '0;
      out_row  <= '0;
      out_col  <= '0;
      out_last <= 1'b0;
      out_eol  <= 1'b0;
    end else begin
      // Inputs are sampled only on the IDLE->active transition; later
      // changes on dim_m/dim_n/addr_base cannot disturb a running stream.
      if (state == ST_IDLE && start) begin
        m_q      <= dim_m;
        n_q      <= dim_n;
        base_q   <= addr_base;
        offset_q <= '0;
        row_q    <= '0;
        col_q    <= '0;
      end

      // BRAM data for the address issued in READ is stable by CAPTURE.
      if (state == ST_CAPTURE) begin
        out_data <= mem_rd_data;
        out_row  <= row_q;
        out_col  <= col_q;
        out_last <= row_at_end && col_at_end;
        out_eol  <= eol_next;
      end

      // Index advance uses a running offset instead of row*dim_n+col.
      if (xfer) begin
        offset_q <= offset_q + 1'b1;
        if (col_at_end) begin
          col_q <= '0;
          row_q <= row_q + 5'd1;
        end else begin
          col_q <= col_q + 5'd1;
        end
      end
    end
  end

endmodule

`default_nettype wire
